// File: rtl/countdown_timer_mmss_pkg.sv
// Shared encodings for the MM:SS countdown timer: FSM state codes and BCD digit limits.
package countdown_timer_mmss_pkg;

   typedef logic [3:0] bcd_t;

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StRun   = 2'd1;
   localparam logic [1:0] StPause = 2'd2;
   localparam logic [1:0] StDone  = 2'd3;

   localparam bcd_t SEC_TENS_MAX = 4'd5;
   localparam bcd_t ONES_MAX     = 4'd9;
   localparam bcd_t MIN_TENS_MAX = 4'd5;

   // Saturate an out-of-range BCD digit to its maximum.
   function automatic bcd_t bcd_clamp(input bcd_t val, input bcd_t max);
      return (val > max) ? max : val;
   endfunction

endpackage

// File: rtl/countdown_timer_mmss_if.sv
// Control/load/status bundle between the timer and whoever drives it.
interface countdown_timer_mmss_if;
   import countdown_timer_mmss_pkg::*;

   logic tick_1hz;
   logic load;
   bcd_t ld_min_tens;
   bcd_t ld_min_ones;
   bcd_t ld_sec_tens;
   bcd_t ld_sec_ones;
   logic start;
   logic stop;
   logic ack;
   bcd_t min_tens;
   bcd_t min_ones;
   bcd_t sec_tens;
   bcd_t sec_ones;
   logic running;
   logic done;
   logic alarm;

   modport master (
      output tick_1hz, load, ld_min_tens, ld_min_ones, ld_sec_tens, ld_sec_ones,
      output start, stop, ack,
      input  min_tens, min_ones, sec_tens, sec_ones, running, done, alarm
   );

   modport slave (
      input  tick_1hz, load, ld_min_tens, ld_min_ones, ld_sec_tens, ld_sec_ones,
      input  start, stop, ack,
      output min_tens, min_ones, sec_tens, sec_ones, running, done, alarm
   );

endinterface

// File: rtl/countdown_timer_mmss_down_counter_digit.sv
// One BCD digit of the down-chain: clamped load, decrement with wrap to MAX, borrow-out.
module down_counter_digit
   import countdown_timer_mmss_pkg::*;
#(
   parameter bcd_t MAX = 4'd9
) (
   input  logic clk,
   input  logic reset,
   input  logic load,
   input  bcd_t ld_val,
   input  logic dec_en,
   output bcd_t digit,
   output logic borrow_out
);

   bcd_t digit_d;

   assign borrow_out = dec_en && (digit == 4'd0);

   always_comb begin
      digit_d = digit;
      if (load) begin
         digit_d = bcd_clamp(ld_val, MAX);
      end else if (dec_en) begin
         digit_d = (digit == 4'd0) ? MAX : digit - 4'd1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         digit <= 4'd0;
      end else begin
         digit <= digit_d;
      end
   end

endmodule

// File: rtl/countdown_timer_mmss.sv
// MM:SS countdown timer: FSM, combinational borrow chain across four BCD digits, and
// a bounded alarm that auto-clears after ALARM_TICKS seconds.
module countdown_timer_mmss
   import countdown_timer_mmss_pkg::*;
#(
   parameter int unsigned ALARM_TICKS = 10
) (
   input logic                          clk,
   input logic                          reset,
   countdown_timer_mmss_if.slave        bus
);

   localparam logic [3:0] AlarmLimit = 4'(ALARM_TICKS);

   logic [1:0] state_q, state_d;
   logic       alarm_q, alarm_d;
   logic [3:0] alarm_cnt_q, alarm_cnt_d;
   logic       done_q, done_d;
   logic       running_q;

   bcd_t sec_ones, sec_tens, min_ones, min_tens;
   logic borrow_so, borrow_st, borrow_mo, borrow_mt;

   logic value_zero;
   logic value_one;
   logic count_en;
   logic expire;
   logic start_ok;

   assign value_zero = (min_tens == 4'd0) && (min_ones == 4'd0) &&
                       (sec_tens == 4'd0) && (sec_ones == 4'd0);
   assign value_one  = (min_tens == 4'd0) && (min_ones == 4'd0) &&
                       (sec_tens == 4'd0) && (sec_ones == 4'd1);

   // stop and load both suppress the decrement in the cycle they arrive
   assign count_en = (state_q == StRun) && bus.tick_1hz && !bus.stop && !bus.load &&
                     !value_zero;
   // top borrow can only fire on an underflow, which value_zero gating rules out
   assign expire   = count_en && value_one && !borrow_mt;
   assign start_ok = bus.start && !bus.stop;

   down_counter_digit #(.MAX(ONES_MAX)) u_sec_ones (
      .clk       (clk),
      .reset     (reset),
      .load      (bus.load),
      .ld_val    (bus.ld_sec_ones),
      .dec_en    (count_en),
      .digit     (sec_ones),
      .borrow_out(borrow_so)
   );

   down_counter_digit #(.MAX(SEC_TENS_MAX)) u_sec_tens (
      .clk       (clk),
      .reset     (reset),
      .load      (bus.load),
      .ld_val    (bus.ld_sec_tens),
      .dec_en    (borrow_so),
      .digit     (sec_tens),
      .borrow_out(borrow_st)
   );

   down_counter_digit #(.MAX(ONES_MAX)) u_min_ones (
      .clk       (clk),
      .reset     (reset),
      .load      (bus.load),
      .ld_val    (bus.ld_min_ones),
      .dec_en    (borrow_st),
      .digit     (min_ones),
      .borrow_out(borrow_mo)
   );

   down_counter_digit #(.MAX(MIN_TENS_MAX)) u_min_tens (
      .clk       (clk),
      .reset     (reset),
      .load      (bus.load),
      .ld_val    (bus.ld_min_tens),
      .dec_en    (borrow_mo),
      .digit     (min_tens),
      .borrow_out(borrow_mt)
   );

   always_comb begin
      state_d     = state_q;
      alarm_d     = alarm_q;
      alarm_cnt_d = alarm_cnt_q;
      done_d      = 1'b0;
      if (bus.load) begin
         state_d     = StIdle;
         alarm_d     = 1'b0;
         alarm_cnt_d = 4'd0;
      end else begin
         case (state_q)
            StIdle, StPause: begin
               if (start_ok && !value_zero) begin
                  state_d = StRun;
               end
            end
            StRun: begin
               if (bus.stop) begin
                  state_d = StPause;
               end else if (expire) begin
                  state_d     = StDone;
                  done_d      = 1'b1;
                  alarm_d     = 1'b1;
                  alarm_cnt_d = 4'd0;
               end
            end
            StDone: begin
               if (start_ok) begin
                  state_d     = StIdle;
                  alarm_d     = 1'b0;
                  alarm_cnt_d = 4'd0;
               end else if (bus.ack) begin
                  alarm_d = 1'b0;
               end else if (alarm_q && bus.tick_1hz) begin
                  alarm_cnt_d = alarm_cnt_q + 4'd1;
                  if (alarm_cnt_d == AlarmLimit) begin
                     alarm_d = 1'b0;
                  end
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= StIdle;
         alarm_q     <= 1'b0;
         alarm_cnt_q <= 4'd0;
         done_q      <= 1'b0;
         running_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         alarm_q     <= alarm_d;
         alarm_cnt_q <= alarm_cnt_d;
         done_q      <= done_d;
         running_q   <= (state_d == StRun);
      end
   end

   assign bus.min_tens = min_tens;
   assign bus.min_ones = min_ones;
   assign bus.sec_tens = sec_tens;
   assign bus.sec_ones = sec_ones;
   assign bus.running  = running_q;
   assign bus.done     = done_q;
   assign bus.alarm    = alarm_q;

endmodule

// File: tb/tb_countdown_timer_mmss.sv
// Directed bench for countdown_timer_mmss: hand-computed MM:SS values and status flags.
module tb_countdown_timer_mmss;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_errors;

   countdown_timer_mmss_if bus ();

   countdown_timer_mmss #(.ALARM_TICKS(10)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] value();
      return {bus.min_tens, bus.min_ones, bus.sec_tens, bus.sec_ones};
   endfunction

   task automatic step();
      @(negedge clk);
   endtask

   task automatic do_load(input logic [15:0] v);
      {bus.ld_min_tens, bus.ld_min_ones, bus.ld_sec_tens, bus.ld_sec_ones} = v;
      bus.load = 1'b1;
      step();
      bus.load = 1'b0;
   endtask

   task automatic do_start();
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
   endtask

   task automatic do_stop();
      bus.stop = 1'b1;
      step();
      bus.stop = 1'b0;
   endtask

   task automatic do_tick();
      bus.tick_1hz = 1'b1;
      step();
      bus.tick_1hz = 1'b0;
   endtask

   initial begin
      n_checks     = 0;
      n_errors     = 0;
      reset        = 1'b0;
      bus.tick_1hz = 1'b0;
      bus.load     = 1'b0;
      bus.start    = 1'b0;
      bus.stop     = 1'b0;
      bus.ack      = 1'b0;
      {bus.ld_min_tens, bus.ld_min_ones, bus.ld_sec_tens, bus.ld_sec_ones} = 16'h0000;
      step();
      step();
      check("rst_value", 32'(value()), 32'h0000);
      check("rst_running", 32'(bus.running), 0);
      check("rst_done", 32'(bus.done), 0);
      check("rst_alarm", 32'(bus.alarm), 0);
      check("rst_state", 32'(dut.state_q), 0);
      reset = 1'b1;
      step();

      // Basic expiry from 00:03
      do_load(16'h0003);
      check("ld3_value", 32'(value()), 32'h0003);
      check("ld3_state", 32'(dut.state_q), 0);
      do_start();
      check("ld3_running", 32'(bus.running), 1);
      do_tick();
      check("t1_value", 32'(value()), 32'h0002);
      check("t1_done", 32'(bus.done), 0);
      do_tick();
      check("t2_value", 32'(value()), 32'h0001);
      check("t2_done", 32'(bus.done), 0);
      do_tick();
      check("t3_value", 32'(value()), 32'h0000);
      check("t3_done", 32'(bus.done), 1);
      check("t3_alarm", 32'(bus.alarm), 1);
      check("t3_state", 32'(dut.state_q), 3);
      check("t3_running", 32'(bus.running), 0);
      step();
      check("t3_done_once", 32'(bus.done), 0);
      do_tick();
      check("done_hold_value", 32'(value()), 32'h0000);
      check("done_hold_pulse", 32'(bus.done), 0);

      // Full borrow 10:00 -> 09:59
      do_load(16'h1000);
      check("ld10_alarm", 32'(bus.alarm), 0);
      do_start();
      do_tick();
      check("borrow_value", 32'(value()), 32'h0959);

      // Pause / resume, and start+stop collision in PAUSE
      do_load(16'h0005);
      do_start();
      do_tick();
      do_tick();
      check("pre_pause", 32'(value()), 32'h0003);
      do_stop();
      check("pause_running", 32'(bus.running), 0);
      check("pause_state", 32'(dut.state_q), 2);
      do_tick();
      do_tick();
      do_tick();
      check("pause_hold", 32'(value()), 32'h0003);
      bus.start = 1'b1;
      bus.stop  = 1'b1;
      step();
      bus.start = 1'b0;
      bus.stop  = 1'b0;
      check("startstop_state", 32'(dut.state_q), 2);
      check("startstop_running", 32'(bus.running), 0);
      do_start();
      check("resume_running", 32'(bus.running), 1);
      do_tick();
      check("resume_value", 32'(value()), 32'h0002);
      do_stop();
      do_tick();
      check("idle_tick_hold", 32'(value()), 32'h0002);

      // Clamp and start-at-zero
      do_load(16'h7FAC);
      check("clamp_value", 32'(value()), 32'h5959);
      do_load(16'h0000);
      do_start();
      check("zero_start_running", 32'(bus.running), 0);
      check("zero_start_state", 32'(dut.state_q), 0);

      // Alarm auto-clear after 10 ticks
      do_load(16'h0001);
      do_start();
      do_tick();
      check("exp2_alarm", 32'(bus.alarm), 1);
      for (int i = 0; i < 9; i++) do_tick();
      check("alarm_after9", 32'(bus.alarm), 1);
      do_tick();
      check("alarm_after10", 32'(bus.alarm), 0);
      check("alarm_state", 32'(dut.state_q), 3);

      // ack after 2 ticks
      do_load(16'h0001);
      do_start();
      do_tick();
      do_tick();
      do_tick();
      check("ack_pre_alarm", 32'(bus.alarm), 1);
      bus.ack = 1'b1;
      step();
      bus.ack = 1'b0;
      check("ack_alarm", 32'(bus.alarm), 0);
      check("ack_state", 32'(dut.state_q), 3);
      do_start();
      check("done_start_state", 32'(dut.state_q), 0);
      check("done_start_running", 32'(bus.running), 0);

      // load + tick in RUN
      do_load(16'h0002);
      do_start();
      bus.tick_1hz = 1'b1;
      do_load(16'h0045);
      bus.tick_1hz = 1'b0;
      check("ldtick_value", 32'(value()), 32'h0045);
      check("ldtick_state", 32'(dut.state_q), 0);

      // Async reset mid-run
      do_load(16'h1234);
      do_start();
      check("pre_rst_value", 32'(value()), 32'h1234);
      #2 reset = 1'b0;
      #1;
      check("arst_value", 32'(value()), 32'h0000);
      check("arst_state", 32'(dut.state_q), 0);
      check("arst_alarm", 32'(bus.alarm), 0);
      check("arst_running", 32'(bus.running), 0);
      check("arst_done", 32'(bus.done), 0);
      step();
      reset = 1'b1;
      step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
